// File: rtl/pl_stage_reg.sv
// pl_stage_reg: parametrised pipeline stage register with valid/ready,
// flush and stall counter; optional skid entry via PL_STAGE_SKID_EN.
module pl_stage_reg #(
  parameter int unsigned         DATA_W    = 24,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0,
  parameter logic [DATA_W-1:0]   FLUSH_VAL = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  input  logic              flush,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_acc;
  logic              w_drn;

`ifdef PL_STAGE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_up_ready;

  assign w_main_valid = (r_state != S_EMPTY);
  assign w_acc        = up_valid && r_up_ready;
  assign w_drn        = w_main_valid && dn_ready;
  assign up_ready     = r_up_ready;

  // next-state: occupancy after this edge's accept/drain
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: if (w_acc) w_next = S_ONE;
      S_ONE: begin
        if (w_acc && !w_drn)      w_next = S_TWO;
        else if (!w_acc && w_drn) w_next = S_EMPTY;
      end
      S_TWO:   if (w_drn) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
    if (flush) w_next = S_EMPTY;
  end

  // state register and registered ready (no path from dn_ready)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_up_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_up_ready <= (w_next != S_TWO);
    end
  end

  // data entries: main always holds the older payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_data <= RESET_VAL;
      r_skid_data <= RESET_VAL;
    end else if (flush) begin
      r_main_data <= FLUSH_VAL;
      r_skid_data <= FLUSH_VAL;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_acc) r_main_data <= up_data;
        S_ONE: begin
          if (w_acc && w_drn) r_main_data <= up_data;
          else if (w_acc)     r_skid_data <= up_data;
        end
        S_TWO:   if (w_drn) r_main_data <= r_skid_data;
        default: ;
      endcase
    end
  end

`else

  logic r_main_valid;

  assign w_main_valid = r_main_valid;
  assign up_ready     = !r_main_valid || dn_ready;
  assign w_acc        = up_valid && up_ready;
  assign w_drn        = r_main_valid && dn_ready;

  // single entry: load on accept, empty on drain-only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_data  <= FLUSH_VAL;
    end else if (w_acc) begin
      r_main_valid <= 1'b1;
      r_main_data  <= up_data;
    end else if (w_drn) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

  // saturating count of stalled cycles; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !dn_ready && !flush) begin
      if (r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign dn_valid  = w_main_valid;
  assign dn_data   = r_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule
